fifo_mem_ctrl: RTL and testbench
================================

Name: fifo_mem_ctrl

Overview:
- Synchronous FIFO controller that sequences the 256x8 dual-pointer memory array.
- Generates WE, WR_PTR and RD_PTR for the array, tracks occupancy, and reports full, empty and threshold status to producer and consumer logic.
- Array read is asynchronous at RD_PTR, so the FIFO is first-word-fall-through: array Dout is valid whenever EMPTY=0.
- Sits between producer/consumer handshakes and the array instance; no data passes through this block.

Parameters:
- ADDR_WIDTH, 8, pointer width; depth = 2**ADDR_WIDTH = 256.
- AF_LEVEL, 252, ALMOST_FULL asserted when COUNT >= AF_LEVEL.
- AE_LEVEL, 4, ALMOST_EMPTY asserted when COUNT <= AE_LEVEL.

Ports:
- CLK  in  1  single clock; all state updates on posedge CLK.
- RST  in  1  synchronous, active-high reset, sampled on posedge CLK.
- WR_REQ  in  1  producer push request; the data sits on array Din this cycle.
- RD_REQ  in  1  consumer pop request; consumer takes array Dout this cycle.
- WE  out  1  array write enable (combinational).
- WR_PTR  out  ADDR_WIDTH  array write address (registered).
- RD_PTR  out  ADDR_WIDTH  array read address (registered).
- COUNT  out  ADDR_WIDTH+1  occupancy, 0..256 (registered).
- FULL  out  1  COUNT == 2**ADDR_WIDTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL.
- WR_ACK  out  1  push accepted this cycle (combinational, equals WE).
- RD_ACK  out  1  pop accepted this cycle (combinational).
- OVERFLOW  out  1  sticky: a push was rejected.
- UNDERFLOW  out  1  sticky: a pop was rejected.

Behaviour:
- Reset:
  - Applies when RST=1 at a posedge CLK; it has priority over all requests.
  - State after reset: WR_PTR=0, RD_PTR=0, COUNT=0, OVERFLOW=0, UNDERFLOW=0.
  - Hence EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0.
  - WE=0 and both ACKs=0 while RST=1.
  - Reset mid-stream discards all contents; no write reaches the array in the reset cycle.
- Acceptance (combinational, from registered state):
  - rd_ok = RD_REQ & ~EMPTY
  - wr_ok = WR_REQ & (~FULL | rd_ok)
  - WE = WR_ACK = wr_ok & ~RST; RD_ACK = rd_ok & ~RST.
- Update on posedge CLK when RST=0:
  - wr_ok: WR_PTR <= WR_PTR+1, wrapping modulo 2**ADDR_WIDTH (255 -> 0).
  - rd_ok: RD_PTR <= RD_PTR+1, same wrap.
  - COUNT: +1 if wr_ok only; -1 if rd_ok only; unchanged if both or neither.
- Simultaneous push and pop:
  - When EMPTY: pop rejected, push accepted, COUNT 0 -> 1. UNDERFLOW sets.
  - When FULL: both accepted, COUNT stays 256, no overflow.
  - Otherwise: both accepted.
- Latency:
  - Pushed word is visible on Dout (when it is at the head) one cycle after its WE cycle.
  - EMPTY deasserts one cycle after the first push.
  - FULL asserts the cycle after the 256th net push.
- Error flags:
  - OVERFLOW <= 1 on any cycle with WR_REQ & ~wr_ok.
  - UNDERFLOW <= 1 on any cycle with RD_REQ & ~rd_ok.
  - Both hold until RST.
  - A rejected request has no effect on pointers, COUNT or the array.
- Status flags are pure decodes of registered COUNT, so they are glitch-free relative to CLK.
- No combinational path exists from WR_REQ or RD_REQ to any registered output.
- Invariant: WR_PTR - RD_PTR (mod 256) == COUNT[7:0] at all times, with COUNT[8]=1 only when the two pointers are equal.

Test Plan:
- Reset then idle -> EMPTY=1, FULL=0, COUNT=0, both pointers 0, WE=0. Assert RST for one cycle mid-stream at COUNT=10 -> same values next cycle.
- Push 0x00..0xFF (256 cycles), then pop 256 -> FULL rises after the 256th push with COUNT=256. Pops return 0x00..0xFF in order. EMPTY=1 at end; both pointers wrapped back to 0.
- At FULL, assert WR_REQ alone -> WE=0, WR_ACK=0, OVERFLOW=1, COUNT stays 256. Then WR_REQ+RD_REQ together -> both ACK, COUNT stays 256, WR_PTR and RD_PTR each +1.
- At EMPTY, assert RD_REQ+WR_REQ with Din=0xA5 -> RD_ACK=0, WE=1, UNDERFLOW=1, COUNT=1. Next cycle Dout=0xA5, EMPTY=0.
- Thresholds: fill to COUNT=251 -> ALMOST_FULL=0; one more push -> ALMOST_FULL=1. Drain to COUNT=5 -> ALMOST_EMPTY=0; one more pop -> ALMOST_EMPTY=1.
- Pointer wrap: 300 random push/pop cycles at about 50% each, checked against a scoreboard queue -> data order matches, COUNT equals queue size every cycle, pointer invariant holds, no spurious error flags.

Source files
------------

// File: rtl/fifo_mem_ctrl.sv
// fifo_mem_ctrl: pointer and occupancy sequencer for a 2**ADDR_WIDTH x 8 array.
// First-word-fall-through: the array reads asynchronously at RD_PTR.
module fifo_mem_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int AF_LEVEL   = 252,
   parameter int AE_LEVEL   = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WR_REQ,
   input  logic                  RD_REQ,
   output logic                  WE,
   output logic [ADDR_WIDTH-1:0] WR_PTR,
   output logic [ADDR_WIDTH-1:0] RD_PTR,
   output logic [ADDR_WIDTH:0]   COUNT,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ALMOST_FULL,
   output logic                  ALMOST_EMPTY,
   output logic                  WR_ACK,
   output logic                  RD_ACK,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] AF_C  = AF_LEVEL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_C  = AE_LEVEL[ADDR_WIDTH:0];

   logic rd_ok;
   logic wr_ok;

   // Status flags decode registered COUNT only, so they never glitch.
   assign EMPTY        = (COUNT == '0);
   assign FULL         = (COUNT == DEPTH);
   assign ALMOST_FULL  = (COUNT >= AF_C);
   assign ALMOST_EMPTY = (COUNT <= AE_C);

   // A pop frees a slot in the same cycle, so a push at FULL is still taken.
   assign rd_ok = RD_REQ & ~EMPTY;
   assign wr_ok = WR_REQ & (~FULL | rd_ok);

   assign WE     = wr_ok & ~RST;
   assign WR_ACK = WE;
   assign RD_ACK = rd_ok & ~RST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         WR_PTR    <= '0;
         RD_PTR    <= '0;
         COUNT     <= '0;
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (wr_ok)
            WR_PTR <= WR_PTR + 1'b1;
         if (rd_ok)
            RD_PTR <= RD_PTR + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   COUNT <= COUNT + 1'b1;
            2'b01:   COUNT <= COUNT - 1'b1;
            default: COUNT <= COUNT;
         endcase
         if (WR_REQ & ~wr_ok)
            OVERFLOW <= 1'b1;
         if (RD_REQ & ~rd_ok)
            UNDERFLOW <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Randomized and directed bench for fifo_mem_ctrl, with a queue model
// and a behavioural 256x8 array driven by the DUT's WE/WR_PTR/RD_PTR.
module tb_fifo_mem_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       WR_REQ = 1'b0;
   logic       RD_REQ = 1'b0;
   logic [7:0] din = 8'h00;
   logic       WE, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY;
   logic       WR_ACK, RD_ACK, OVERFLOW, UNDERFLOW;
   logic [7:0] WR_PTR, RD_PTR;
   logic [8:0] COUNT;

   fifo_mem_ctrl #(.ADDR_WIDTH(8), .AF_LEVEL(252), .AE_LEVEL(4)) dut (
      .CLK(CLK), .RST(RST), .WR_REQ(WR_REQ), .RD_REQ(RD_REQ),
      .WE(WE), .WR_PTR(WR_PTR), .RD_PTR(RD_PTR), .COUNT(COUNT),
      .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL),
      .ALMOST_EMPTY(ALMOST_EMPTY), .WR_ACK(WR_ACK), .RD_ACK(RD_ACK),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: contents as a queue, pointers as running totals.
   logic [7:0] q[$];
   int  wr_total = 0;
   int  rd_total = 0;
   bit  m_ovf = 0;
   bit  m_unf = 0;
   bit  armed = 0;

   // Stand-in for the array instance the controller sequences.
   logic [7:0] mem [256];
   logic       we_s;
   logic [7:0] wa_s;
   logic [7:0] din_s;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: inputs are stable at negedge, state is from last edge.
   initial begin
      forever begin
         @(negedge CLK);
         we_s  = WE;
         wa_s  = WR_PTR;
         din_s = din;
         if (armed) begin
            int  n;
            bit  e_rd, e_wr;
            n    = q.size();
            e_rd = RD_REQ && (n > 0);
            e_wr = WR_REQ && ((n < 256) || e_rd);
            chk("count", 32'(COUNT), 32'(n));
            chk("wr_ptr", 32'(WR_PTR), 32'(wr_total % 256));
            chk("rd_ptr", 32'(RD_PTR), 32'(rd_total % 256));
            chk("full", 32'(FULL), 32'(n == 256));
            chk("empty", 32'(EMPTY), 32'(n == 0));
            chk("almost_full", 32'(ALMOST_FULL), 32'(n >= 252));
            chk("almost_empty", 32'(ALMOST_EMPTY), 32'(n <= 4));
            chk("we", 32'(WE), 32'(e_wr && !RST));
            chk("wr_ack", 32'(WR_ACK), 32'(e_wr && !RST));
            chk("rd_ack", 32'(RD_ACK), 32'(e_rd && !RST));
            chk("overflow", 32'(OVERFLOW), 32'(m_ovf));
            chk("underflow", 32'(UNDERFLOW), 32'(m_unf));
            if (n > 0)
               chk("dout", 32'(mem[RD_PTR]), 32'(q[0]));
         end
      end
   end

   // One clock: apply inputs, let the edge happen, then advance the model.
   task automatic step(input bit wr, input bit rd, input logic [7:0] d,
                       input bit rst);
      bit r_ok, w_ok;
      WR_REQ = wr;
      RD_REQ = rd;
      din    = d;
      RST    = rst;
      @(posedge CLK);
      #1;
      if (we_s)
         mem[wa_s] = din_s;
      if (rst) begin
         q.delete();
         wr_total = 0;
         rd_total = 0;
         m_ovf = 0;
         m_unf = 0;
      end else begin
         r_ok = rd && (q.size() > 0);
         w_ok = wr && ((q.size() < 256) || r_ok);
         if (wr && !w_ok) m_ovf = 1;
         if (rd && !r_ok) m_unf = 1;
         if (r_ok) begin
            void'(q.pop_front());
            rd_total++;
         end
         if (w_ok) begin
            q.push_back(d);
            wr_total++;
         end
      end
      armed = 1;
   endtask

   initial begin
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);
      chk("lit_reset_count", 32'(COUNT), 32'd0);
      chk("lit_reset_empty", 32'(EMPTY), 32'd1);
      chk("lit_reset_full", 32'(FULL), 32'd0);
      chk("lit_reset_ptrs", {16'h0, WR_PTR, RD_PTR}, 32'h0);

      // Reset mid-stream at COUNT=10, with a push present in the reset cycle.
      for (int i = 0; i < 10; i++) step(1, 0, 8'(i), 0);
      chk("lit_count10", 32'(COUNT), 32'd10);
      step(1, 0, 8'h77, 1);
      chk("lit_midrst_count", 32'(COUNT), 32'd0);
      chk("lit_midrst_wrptr", 32'(WR_PTR), 32'd0);
      chk("lit_midrst_empty", 32'(EMPTY), 32'd1);

      // Fill with 0x00..0xFF, drain in order.
      for (int i = 0; i < 256; i++) step(1, 0, 8'(i), 0);
      chk("lit_fill_full", 32'(FULL), 32'd1);
      chk("lit_fill_count", 32'(COUNT), 32'd256);
      for (int i = 0; i < 256; i++) begin
         chk("lit_drain_data", 32'(mem[RD_PTR]), 32'(i));
         step(0, 1, 8'h00, 0);
      end
      chk("lit_drain_empty", 32'(EMPTY), 32'd1);
      chk("lit_drain_ptrs", {16'h0, WR_PTR, RD_PTR}, 32'h0);

      // Behaviour at FULL.
      for (int i = 0; i < 256; i++) step(1, 0, 8'(i ^ 8'h3C), 0);
      step(1, 0, 8'hEE, 0);
      chk("lit_full_ovf", 32'(OVERFLOW), 32'd1);
      chk("lit_full_count", 32'(COUNT), 32'd256);
      chk("lit_full_wrptr", 32'(WR_PTR), 32'd0);
      step(1, 1, 8'hEF, 0);
      chk("lit_both_count", 32'(COUNT), 32'd256);
      chk("lit_both_ptrs", {16'h0, WR_PTR, RD_PTR}, 32'h0101);
      for (int i = 0; i < 256; i++) step(0, 1, 8'h00, 0);
      chk("lit_full_drain_empty", 32'(EMPTY), 32'd1);

      // Simultaneous push and pop at EMPTY.
      step(0, 0, 8'h00, 1);
      step(1, 1, 8'hA5, 0);
      chk("lit_empty_unf", 32'(UNDERFLOW), 32'd1);
      chk("lit_empty_count", 32'(COUNT), 32'd1);
      chk("lit_empty_dout", 32'(mem[RD_PTR]), 32'hA5);
      chk("lit_empty_flag", 32'(EMPTY), 32'd0);

      // Threshold boundaries.
      step(0, 0, 8'h00, 1);
      for (int i = 0; i < 251; i++) step(1, 0, 8'(i), 0);
      chk("lit_af_251", 32'(ALMOST_FULL), 32'd0);
      step(1, 0, 8'h55, 0);
      chk("lit_af_252", 32'(ALMOST_FULL), 32'd1);
      for (int i = 0; i < 247; i++) step(0, 1, 8'h00, 0);
      chk("lit_ae_5", 32'(ALMOST_EMPTY), 32'd0);
      chk("lit_count5", 32'(COUNT), 32'd5);
      step(0, 1, 8'h00, 0);
      chk("lit_ae_4", 32'(ALMOST_EMPTY), 32'd1);

      // Random traffic from a half-full start, crossing pointer wrap.
      step(0, 0, 8'h00, 1);
      for (int i = 0; i < 128; i++) step(1, 0, 8'($urandom), 0);
      for (int i = 0; i < 300; i++)
         step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              8'($urandom), 0);
      chk("lit_rand_no_ovf", 32'(OVERFLOW), 32'(m_ovf));
      chk("lit_rand_no_unf", 32'(UNDERFLOW), 32'(m_unf));

      // Random traffic near the edges to exercise sticky error flags.
      step(0, 0, 8'h00, 1);
      for (int i = 0; i < 300; i++)
         step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
              8'($urandom), 0);
      step(0, 0, 8'h00, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
